// File: rtl/cnn_tile_scheduler.sv
// Walks row x input-tile x output-tile beats for one CNN layer, fetching a weight tile per output tile.
// Beats are issued combinationally on dat_rdy while running; DRAIN flushes the datapath before done.
module cnn_tile_scheduler #(
  parameter int HEIGHT_W  = 8,
  parameter int WDIV_W    = 6,
  parameter int DRAIN_CYC = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [HEIGHT_W-1:0] height,
  input  logic [WDIV_W-1:0]   Win_div_Tin,
  input  logic [WDIV_W-1:0]   Wout_div_Tout,
  input  logic                dat_rdy,
  input  logic                wt_ack,
  output logic                wt_req,
  output logic                dat_vld,
  output logic [HEIGHT_W-1:0] h_idx,
  output logic [WDIV_W-1:0]   win_idx,
  output logic [WDIV_W-1:0]   wout_idx,
  output logic                tile_first,
  output logic                tile_last,
  output logic                busy,
  output logic                done,
  output logic                cfg_err
);

  localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WT_REQ,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [HEIGHT_W-1:0] r_height;
  logic [WDIV_W-1:0]   r_win;
  logic [WDIV_W-1:0]   r_wout;
  logic [HEIGHT_W-1:0] r_h;
  logic [WDIV_W-1:0]   r_wi;
  logic [WDIV_W-1:0]   r_wo;
  logic [DCW-1:0]      r_dcnt;
  logic                r_cfg_err;

  state_t              w_state_nxt;
  logic [HEIGHT_W-1:0] w_height_nxt;
  logic [WDIV_W-1:0]   w_win_nxt;
  logic [WDIV_W-1:0]   w_wout_nxt;
  logic [HEIGHT_W-1:0] w_h_nxt;
  logic [WDIV_W-1:0]   w_wi_nxt;
  logic [WDIV_W-1:0]   w_wo_nxt;
  logic [DCW-1:0]      w_dcnt_nxt;
  logic                w_cfg_err_nxt;

  logic w_cfg_ok;
  logic w_beat;
  logic w_h_last;
  logic w_wi_last;
  logic w_wo_last;

  assign w_cfg_ok = (|height) && (|Win_div_Tin) && (|Wout_div_Tout);
  assign w_beat   = (r_state == S_RUN) && dat_rdy;

  // Latched configs are never zero while running, so the minus-one cannot underflow.
  assign w_h_last  = (r_h  == r_height - HEIGHT_W'(1));
  assign w_wi_last = (r_wi == r_win    - WDIV_W'(1));
  assign w_wo_last = (r_wo == r_wout   - WDIV_W'(1));

  always_comb begin
    w_state_nxt   = r_state;
    w_height_nxt  = r_height;
    w_win_nxt     = r_win;
    w_wout_nxt    = r_wout;
    w_h_nxt       = r_h;
    w_wi_nxt      = r_wi;
    w_wo_nxt      = r_wo;
    w_dcnt_nxt    = r_dcnt;
    w_cfg_err_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_cfg_ok) begin
            w_state_nxt  = S_WT_REQ;
            w_height_nxt = height;
            w_win_nxt    = Win_div_Tin;
            w_wout_nxt   = Wout_div_Tout;
            w_h_nxt      = '0;
            w_wi_nxt     = '0;
            w_wo_nxt     = '0;
            w_dcnt_nxt   = '0;
          end else begin
            w_cfg_err_nxt = 1'b1;
          end
        end
      end
      S_WT_REQ: begin
        if (wt_ack) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (dat_rdy) begin
          if (!w_h_last) begin
            w_h_nxt = r_h + HEIGHT_W'(1);
          end else begin
            w_h_nxt = '0;
            if (!w_wi_last) begin
              w_wi_nxt = r_wi + WDIV_W'(1);
            end else begin
              w_wi_nxt = '0;
              if (!w_wo_last) begin
                w_wo_nxt    = r_wo + WDIV_W'(1);
                w_state_nxt = S_WT_REQ;
              end else begin
                w_wo_nxt    = '0;
                w_dcnt_nxt  = '0;
                w_state_nxt = S_DRAIN;
              end
            end
          end
        end
      end
      S_DRAIN: begin
        if (r_dcnt == DCW'(DRAIN_CYC - 1)) w_state_nxt = S_DONE;
        else                               w_dcnt_nxt  = r_dcnt + DCW'(1);
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Abort overrides every progression decision made above.
    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_h_nxt     = '0;
      w_wi_nxt    = '0;
      w_wo_nxt    = '0;
      w_dcnt_nxt  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_height  <= '0;
      r_win     <= '0;
      r_wout    <= '0;
      r_h       <= '0;
      r_wi      <= '0;
      r_wo      <= '0;
      r_dcnt    <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_height  <= w_height_nxt;
      r_win     <= w_win_nxt;
      r_wout    <= w_wout_nxt;
      r_h       <= w_h_nxt;
      r_wi      <= w_wi_nxt;
      r_wo      <= w_wo_nxt;
      r_dcnt    <= w_dcnt_nxt;
      r_cfg_err <= w_cfg_err_nxt;
    end
  end

  assign wt_req     = (r_state == S_WT_REQ);
  assign dat_vld    = w_beat;
  assign h_idx      = r_h;
  assign win_idx    = r_wi;
  assign wout_idx   = r_wo;
  assign tile_first = w_beat && (r_h == '0) && (r_wi == '0);
  assign tile_last  = w_beat && w_h_last && w_wi_last;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_cnn_tile_scheduler.sv
// Randomized bench for cnn_tile_scheduler against a nested-loop beat list model.
module tb_cnn_tile_scheduler;

  localparam int DRAIN_CYC = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] height;
  logic [5:0] Win_div_Tin;
  logic [5:0] Wout_div_Tout;
  logic       dat_rdy;
  logic       wt_ack;
  logic       wt_req;
  logic       dat_vld;
  logic [7:0] h_idx;
  logic [5:0] win_idx;
  logic [5:0] wout_idx;
  logic       tile_first;
  logic       tile_last;
  logic       busy;
  logic       done;
  logic       cfg_err;

  int n_vec = 0;
  int n_err = 0;

  cnn_tile_scheduler #(.HEIGHT_W(8), .WDIV_W(6), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .height(height), .Win_div_Tin(Win_div_Tin), .Wout_div_Tout(Wout_div_Tout),
    .dat_rdy(dat_rdy), .wt_ack(wt_ack), .wt_req(wt_req), .dat_vld(dat_vld),
    .h_idx(h_idx), .win_idx(win_idx), .wout_idx(wout_idx),
    .tile_first(tile_first), .tile_last(tile_last),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected beat order: wout outermost, then win, then h; each entry is {first,last,wo,wi,h}.
  task automatic run_layer(input int hh, input int wi, input int wo, input int rdy_pct, input int ack_dly);
    logic [31:0] exp_q[$];
    logic [31:0] got;
    int beats = 0, eps = 0, errs = 0, last_beat = 0, req_cyc = 0;
    bit prev_req = 0, fin = 0;
    for (int o = 0; o < wo; o++)
      for (int i = 0; i < wi; i++)
        for (int h = 0; h < hh; h++)
          exp_q.push_back({10'd0, 1'(h == 0 && i == 0), 1'(h == hh - 1 && i == wi - 1),
                           6'(o), 6'(i), 8'(h)});
    @(negedge clk);
    height = 8'(hh); Win_div_Tin = 6'(wi); Wout_div_Tout = 6'(wo);
    start = 1'b1; dat_rdy = 1'b0; wt_ack = 1'b0;
    next_cyc();
    start = 1'b0;
    #1 check_eq("start_busy", {31'd0, busy}, 32'd1);
    for (int cyc = 0; cyc < 20000; cyc++) begin
      wt_ack  = wt_req ? (req_cyc >= ack_dly) : ($urandom_range(0, 3) == 0);
      dat_rdy = ($urandom_range(0, 99) < rdy_pct);
      start   = ($urandom_range(0, 7) == 0);
      height  = 8'($urandom_range(0, 255));
      Win_div_Tin   = 6'($urandom_range(0, 63));
      Wout_div_Tout = 6'($urandom_range(0, 63));
      #1;
      check_eq("vld_gate", {31'd0, dat_vld & ~dat_rdy}, 32'd0);
      if (dat_vld) begin
        got = {10'd0, tile_first, tile_last, wout_idx, win_idx, h_idx};
        if (exp_q.size() == 0) check_eq("extra_beat", got, 32'hFFFF_FFFF);
        else                   check_eq("beat", got, exp_q.pop_front());
        beats++;
        last_beat = cyc;
      end
      if (wt_req && !prev_req) eps++;
      prev_req = wt_req;
      if (cfg_err) errs++;
      if (done) begin
        check_eq("done_lat", 32'(cyc - last_beat), 32'(DRAIN_CYC + 1));
        fin = 1;
        break;
      end
      req_cyc = wt_req ? req_cyc + 1 : 0;
      next_cyc();
    end
    start = 1'b0; wt_ack = 1'b0;
    check_eq("done_seen", {31'd0, fin}, 32'd1);
    check_eq("beat_cnt", 32'(beats), 32'(hh * wi * wo));
    check_eq("wt_eps", 32'(eps), 32'(wo));
    check_eq("no_cfg_err", 32'(errs), 32'd0);
    next_cyc();
    #1 check_eq("idle_after", {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; abort = 1'b1; dat_rdy = 1'b1; wt_ack = 1'b1;
    height = 8'd3; Win_div_Tin = 6'd2; Wout_div_Tout = 6'd2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_wt_req", {31'd0, wt_req}, 32'd0);
    check_eq("rst_dat_vld", {31'd0, dat_vld}, 32'd0);
    check_eq("rst_first", {31'd0, tile_first}, 32'd0);
    check_eq("rst_last", {31'd0, tile_last}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; wt_ack = 1'b0;

    run_layer(3, 2, 2, 100, 1);
    run_layer(1, 1, 1, 100, 1);

    // Zero in any one config field must be rejected.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      height = (k == 0) ? 8'd0 : 8'd3;
      Win_div_Tin   = (k == 1) ? 6'd0 : 6'd2;
      Wout_div_Tout = (k == 2) ? 6'd0 : 6'd2;
      start = 1'b1;
      next_cyc();
      start = 1'b0;
      #1;
      check_eq("cfg_err_pulse", {29'd0, cfg_err, busy, wt_req}, 32'd4);
      next_cyc();
      #1 check_eq("cfg_err_clear", {29'd0, cfg_err, busy, wt_req}, 32'd0);
    end

    for (int n = 0; n < 10; n++)
      run_layer($urandom_range(1, 6), $urandom_range(1, 4), $urandom_range(1, 3),
                $urandom_range(30, 100), $urandom_range(0, 3));

    run_layer(255, 1, 1, 100, 0);
    run_layer(2, 63, 2, 80, 2);
    run_layer(1, 1, 63, 100, 0);

    // Abort on the beat h=1 of the first tile.
    @(negedge clk);
    height = 8'd3; Win_div_Tin = 6'd2; Wout_div_Tout = 6'd2; start = 1'b1;
    next_cyc();
    start = 1'b0;
    begin
      bit hit = 0;
      for (int c = 0; c < 50; c++) begin
        wt_ack = wt_req; dat_rdy = 1'b1;
        #1;
        if (dat_vld && h_idx == 8'd1 && win_idx == 6'd0 && wout_idx == 6'd0) begin
          abort = 1'b1; hit = 1; break;
        end
        next_cyc();
      end
      check_eq("abort_hit", {31'd0, hit}, 32'd1);
    end
    next_cyc();
    abort = 1'b0; wt_ack = 1'b0;
    #1 check_eq("abort_idle", {30'd0, busy, dat_vld}, 32'd0);
    begin
      int dn = 0;
      for (int c = 0; c < 8; c++) begin next_cyc(); #1 if (done) dn++; end
      check_eq("abort_no_done", 32'(dn), 32'd0);
    end
    run_layer(3, 2, 2, 100, 1);

    // Reset while draining.
    @(negedge clk);
    height = 8'd1; Win_div_Tin = 6'd1; Wout_div_Tout = 6'd1; start = 1'b1;
    next_cyc();
    start = 1'b0;
    begin
      bit hit = 0;
      for (int c = 0; c < 50; c++) begin
        wt_ack = wt_req; dat_rdy = 1'b1;
        #1;
        if (dat_vld) begin hit = 1; break; end
        next_cyc();
      end
      check_eq("drain_beat", {31'd0, hit}, 32'd1);
    end
    next_cyc();
    next_cyc();
    #1 check_eq("in_drain", {30'd0, busy, done}, 32'd2);
    rst_n = 1'b0;
    next_cyc();
    rst_n = 1'b1;
    #1 check_eq("drain_rst", {30'd0, busy, done}, 32'd0);
    begin
      int dn = 0;
      for (int c = 0; c < 8; c++) begin next_cyc(); #1 if (done) dn++; end
      check_eq("rst_no_done", 32'(dn), 32'd0);
    end
    run_layer(2, 2, 1, 60, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cnn_tile_scheduler.md
CNN_TILE_SCHEDULER -- requirements
Module: cnn_tile_scheduler

Interface
REQ-001 Parameter HEIGHT_W, default 8: width of the height config and the row index.
REQ-002 Parameter WDIV_W, default 6: width of the Win/Tin and Wout/Tout configs and their indices.
REQ-003 Parameter DRAIN_CYC, default 4: pipeline-flush cycles after the last beat.
REQ-004 clk  in  1  single clock; all logic updates on the rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  one-cycle layer launch request.
REQ-007 abort  in  1  terminates the layer; returns to idle.
REQ-008 height  in  HEIGHT_W  rows per input tile, sampled at accepted start.
REQ-009 Win_div_Tin  in  WDIV_W  input-channel tiles, sampled at accepted start.
REQ-010 Wout_div_Tout  in  WDIV_W  output-channel tiles, sampled at accepted start.
REQ-011 dat_rdy  in  1  feature buffer can supply a word this cycle.
REQ-012 wt_ack  in  1  weight tile loaded; qualified by wt_req.
REQ-013 wt_req  out  1  level request to load the weight tile for wout_idx.
REQ-014 dat_vld  out  1  data beat issued to the datapath this cycle.
REQ-015 h_idx  out  HEIGHT_W  row index of the current beat.
REQ-016 win_idx  out  WDIV_W  input-tile index of the current beat.
REQ-017 wout_idx  out  WDIV_W  output-tile index of the current beat or weight request.
REQ-018 tile_first  out  1  beat with h_idx=0 and win_idx=0 (accumulator clear).
REQ-019 tile_last  out  1  beat with h_idx=height-1 and win_idx=Win_div_Tin-1.
REQ-020 busy  out  1  high in every state except IDLE.
REQ-021 done  out  1  one-cycle pulse at normal layer completion.
REQ-022 cfg_err  out  1  one-cycle pulse when start is rejected for a zero config.

Function
REQ-023 States SHALL be IDLE, WT_REQ, RUN, DRAIN and DONE, held in one registered state variable.
REQ-024 IDLE SHALL go to WT_REQ on start when all three configs are nonzero; it SHALL latch the configs and clear all indices.
REQ-025 If start arrives in IDLE with any config equal to 0, the block SHALL stay in IDLE and assert cfg_err the next cycle.
REQ-026 start SHALL be ignored in every state other than IDLE.
REQ-027 Configuration changes while busy SHALL have no effect; only the latched copies are used.
REQ-028 wt_req SHALL be 1 exactly while in WT_REQ; wt_ack while in WT_REQ SHALL move the block to RUN the next cycle.
REQ-029 wt_ack outside WT_REQ SHALL be ignored.
REQ-030 dat_vld SHALL equal (state==RUN) AND dat_rdy, combinationally.
REQ-031 h_idx, win_idx, wout_idx, tile_first and tile_last SHALL be valid whenever dat_vld=1.
REQ-032 On each beat, h_idx SHALL increment and wrap to 0 after height-1.
REQ-033 win_idx SHALL increment on an h_idx wrap, and wrap to 0 after Win_div_Tin-1.
REQ-034 A tile_last beat with wout_idx < Wout_div_Tout-1 SHALL increment wout_idx and go to WT_REQ.
REQ-035 A tile_last beat with wout_idx = Wout_div_Tout-1 SHALL go to DRAIN with all indices cleared.
REQ-036 DRAIN SHALL last exactly DRAIN_CYC cycles, then go to DONE.
REQ-037 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-038 While dat_rdy=0 in RUN, the indices SHALL hold and no beat SHALL be issued.
REQ-039 abort in any non-IDLE state SHALL force IDLE on the next cycle with indices cleared and no done pulse; abort in IDLE SHALL be ignored.
REQ-040 abort SHALL take priority over wt_ack, over beat advance and over DRAIN/DONE progression.
REQ-041 A layer SHALL issue exactly height*Win_div_Tin*Wout_div_Tout beats and exactly Wout_div_Tout weight requests.
REQ-042 All index comparisons SHALL be made at latched config width, with no overflow for maximum config values.

Reset
REQ-043 With rst_n=0 at a clock edge, the block SHALL enter IDLE and clear all indices and latched configs.
REQ-044 Under reset, wt_req, dat_vld, tile_first, tile_last, busy, done and cfg_err SHALL all be 0.
REQ-045 Reset in the middle of a layer SHALL discard it with no done pulse; the first start after rst_n=1 SHALL be accepted.

Verification
REQ-046 Config height=3, Win=2, Wout=2, dat_rdy=1, wt_ack one cycle after wt_req -> 12 beats and 2 wt_req episodes; tile_first on beats 1 and 7, tile_last on beats 6 and 12; done exactly DRAIN_CYC+1 cycles after beat 12.
REQ-047 Config 1/1/1 -> one beat with tile_first=tile_last=1, then DRAIN, then the done pulse.
REQ-048 start with height=0 -> cfg_err pulse, busy stays 0, wt_req never rises.
REQ-049 dat_rdy toggling 1,0,0,1 in RUN -> beats only on ready cycles; indices frozen while dat_rdy=0; total beat count unchanged.
REQ-050 abort during the beat with h_idx=1 of tile 0 -> IDLE next cycle, no done; a new start then begins at h_idx=0, wout_idx=0.
REQ-051 rst_n=0 in DRAIN, and a second start while in RUN -> reset yields IDLE with no done; the second start is ignored and the beat count is unaffected.
